// File: rtl/dmem_arbiter.sv
// ---------------------------------------------------------------------------
// dmem_arbiter
// Shares one single-port data memory between the pipeline memory stage
// (core port) and a loader/debug port. Grants are combinational. The core
// normally wins; a loader that has waited STARVE_MAX cycles is forced through.
// Loads return one cycle after their grant to whichever port issued them.
//
// Ports
//   clk, rst            : clock, synchronous active-low reset
//   core_req/we/addr/wdata : core access request (addr upper bits ignored)
//   core_gnt, core_stall   : grant this cycle, and request-not-granted stall
//   core_rvalid/rdata      : load return for the core
//   ld_req/we/addr/wdata   : loader access request
//   ld_gnt, ld_rvalid/rdata: loader grant and load return
//   mem_en/we/addr/wdata   : memory access strobe, write enable, address, data
//   mem_rdata              : memory read data, valid one cycle after a read
// ---------------------------------------------------------------------------
module dmem_arbiter #(
  parameter int AW         = 10,
  parameter int DW         = 32,
  parameter int STARVE_MAX = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          core_req,
  input  logic          core_we,
  input  logic [31:0]   core_addr,
  input  logic [DW-1:0] core_wdata,
  output logic          core_gnt,
  output logic          core_stall,
  output logic          core_rvalid,
  output logic [DW-1:0] core_rdata,
  input  logic          ld_req,
  input  logic          ld_we,
  input  logic [31:0]   ld_addr,
  input  logic [DW-1:0] ld_wdata,
  output logic          ld_gnt,
  output logic          ld_rvalid,
  output logic [DW-1:0] ld_rdata,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata
);

  typedef enum logic [1:0] {
    OWN_NONE,
    OWN_CORE,
    OWN_LD
  } rdOwn_e;

  localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

  logic [3:0] r_waitCnt;
  rdOwn_e     r_rdOwn;
  rdOwn_e     w_rdOwnNext;
  logic       w_forceLd;
  logic       w_coreGnt;
  logic       w_ldGnt;
  logic       w_unusedAddrBits;

  // Address bits above the memory size are deliberately ignored.
  assign w_unusedAddrBits = ^{core_addr[31:AW], ld_addr[31:AW]};

  // Arbitration: the loader is forced through once its wait counter reaches
  // the limit; otherwise the core wins. Nothing is granted while in reset.
  assign w_forceLd  = ld_req && (r_waitCnt == STARVE_LIM);
  assign w_coreGnt  = rst && core_req && !w_forceLd;
  assign w_ldGnt    = rst && ld_req && !w_coreGnt;
  assign core_gnt   = w_coreGnt;
  assign ld_gnt     = w_ldGnt;
  assign core_stall = rst && core_req && !w_coreGnt;

  // Loader wait counter: counts cycles the loader asks but loses, saturating
  // at the limit; any loader grant or idle loader cycle starts it over.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_waitCnt <= '0;
    end else if (ld_req && !w_ldGnt) begin
      if (r_waitCnt != STARVE_LIM) begin
        r_waitCnt <= r_waitCnt + 4'd1;
      end
    end else begin
      r_waitCnt <= '0;
    end
  end

  // Memory port mux: the granted requester drives the memory; with no grant
  // every memory output is held at zero.
  always_comb begin
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (w_coreGnt) begin
      mem_en    = 1'b1;
      mem_we    = core_we;
      mem_addr  = core_addr[AW-1:0];
      mem_wdata = core_wdata;
    end else if (w_ldGnt) begin
      mem_en    = 1'b1;
      mem_we    = ld_we;
      mem_addr  = ld_addr[AW-1:0];
      mem_wdata = ld_wdata;
    end
  end

  // Read-owner state register. Reset drops any load granted in the same
  // cycle, so no return appears after reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_rdOwn <= OWN_NONE;
    end else begin
      r_rdOwn <= w_rdOwnNext;
    end
  end

  // Read-owner next state and load-return steering. The owner recorded at
  // the grant edge receives mem_rdata one cycle later; the other port sees
  // zeros. Returns are suppressed while reset is held.
  always_comb begin
    w_rdOwnNext = OWN_NONE;
    core_rvalid = 1'b0;
    core_rdata  = '0;
    ld_rvalid   = 1'b0;
    ld_rdata    = '0;
    if (w_coreGnt && !core_we) begin
      w_rdOwnNext = OWN_CORE;
    end else if (w_ldGnt && !ld_we) begin
      w_rdOwnNext = OWN_LD;
    end
    if (rst) begin
      case (r_rdOwn)
        OWN_CORE: begin
          core_rvalid = 1'b1;
          core_rdata  = mem_rdata;
        end
        OWN_LD: begin
          ld_rvalid = 1'b1;
          ld_rdata  = mem_rdata;
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// ---------------------------------------------------------------------------
// tb_dmem_arbiter
// Self-checking bench for dmem_arbiter with a behavioural memory attached.
// A reference model tracks the loader's wait, the expected load return and
// a shadow copy of memory contents, and every cycle is compared against it.
// ---------------------------------------------------------------------------
module tb_dmem_arbiter;

  localparam int AW         = 10;
  localparam int DW         = 32;
  localparam int STARVE_MAX = 4;
  localparam int DEPTH      = 1 << AW;

  logic          clk;
  logic          rst;
  logic          core_req;
  logic          core_we;
  logic [31:0]   core_addr;
  logic [DW-1:0] core_wdata;
  logic          core_gnt;
  logic          core_stall;
  logic          core_rvalid;
  logic [DW-1:0] core_rdata;
  logic          ld_req;
  logic          ld_we;
  logic [31:0]   ld_addr;
  logic [DW-1:0] ld_wdata;
  logic          ld_gnt;
  logic          ld_rvalid;
  logic [DW-1:0] ld_rdata;
  logic          mem_en;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;

  logic [DW-1:0] memArray [DEPTH];
  logic [DW-1:0] refMem [DEPTH];

  int            checks;
  int            failures;
  int            modelWait;
  int            retOwner;
  logic [DW-1:0] retData;
  logic          expCore;
  logic          expLd;

  logic          lastCoreGnt;
  logic          lastLdGnt;
  logic          lastCoreStall;
  logic          lastCoreRvalid;
  logic [DW-1:0] lastCoreRdata;
  logic          lastLdRvalid;
  logic [DW-1:0] lastLdRdata;
  logic          lastMemEn;
  logic          lastMemWe;
  logic [AW-1:0] lastMemAddr;

  dmem_arbiter #(
    .AW(AW),
    .DW(DW),
    .STARVE_MAX(STARVE_MAX)
  ) dut (
    .clk(clk),
    .rst(rst),
    .core_req(core_req),
    .core_we(core_we),
    .core_addr(core_addr),
    .core_wdata(core_wdata),
    .core_gnt(core_gnt),
    .core_stall(core_stall),
    .core_rvalid(core_rvalid),
    .core_rdata(core_rdata),
    .ld_req(ld_req),
    .ld_we(ld_we),
    .ld_addr(ld_addr),
    .ld_wdata(ld_wdata),
    .ld_gnt(ld_gnt),
    .ld_rvalid(ld_rvalid),
    .ld_rdata(ld_rdata),
    .mem_en(mem_en),
    .mem_we(mem_we),
    .mem_addr(mem_addr),
    .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  // Free-running clock, 10 time units per cycle.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Known memory image; word 28 holds 0xF0 for the directed load check.
  function automatic logic [DW-1:0] initWord(int idx);
    if (idx == 28) return 32'h0000_00F0;
    return 32'(idx) * 32'h9E37_79B1;
  endfunction

  // Behavioural single-port memory: reloaded with its image during reset,
  // otherwise writes on a write strobe and returns read data one cycle later.
  always @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) memArray[i] <= initWord(i);
      mem_rdata <= '0;
    end else if (mem_en) begin
      if (mem_we) memArray[mem_addr] <= mem_wdata;
      else mem_rdata <= memArray[mem_addr];
    end
  end

  // One comparison: counts it, and reports the tag with observed and
  // expected values when it does not hold.
  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One full cycle: inputs were set at the preceding negedge. Shortly after,
  // every output is compared with what the reference model predicts; the
  // model then advances on the rising edge and the task returns at the next
  // negedge, ready for new inputs.
  task automatic applyStimulus();
    logic          forced;
    logic          expStall;
    logic          expEn;
    logic          expWe;
    logic [AW-1:0] expAddr;
    logic [DW-1:0] expWdata;
    #1;
    forced   = ld_req && (modelWait == STARVE_MAX);
    expCore  = rst && core_req && !forced;
    expLd    = rst && ld_req && !expCore;
    expStall = rst && core_req && !expCore;
    expEn    = expCore || expLd;
    expWe    = expCore ? core_we : (expLd ? ld_we : 1'b0);
    expAddr  = expCore ? core_addr[AW-1:0] : (expLd ? ld_addr[AW-1:0] : '0);
    expWdata = expCore ? core_wdata : (expLd ? ld_wdata : '0);

    checkOutput("core_gnt", core_gnt, expCore);
    checkOutput("ld_gnt", ld_gnt, expLd);
    checkOutput("core_stall", core_stall, expStall);
    checkOutput("mem_en", mem_en, expEn);
    checkOutput("mem_we", mem_we, expWe);
    checkOutput("mem_addr", mem_addr, expAddr);
    checkOutput("mem_wdata", mem_wdata, expWdata);
    checkOutput("core_rvalid", core_rvalid, rst && retOwner == 1);
    checkOutput("core_rdata", core_rdata, (rst && retOwner == 1) ? retData : '0);
    checkOutput("ld_rvalid", ld_rvalid, rst && retOwner == 2);
    checkOutput("ld_rdata", ld_rdata, (rst && retOwner == 2) ? retData : '0);

    lastCoreGnt    = core_gnt;
    lastLdGnt      = ld_gnt;
    lastCoreStall  = core_stall;
    lastCoreRvalid = core_rvalid;
    lastCoreRdata  = core_rdata;
    lastLdRvalid   = ld_rvalid;
    lastLdRdata    = ld_rdata;
    lastMemEn      = mem_en;
    lastMemWe      = mem_we;
    lastMemAddr    = mem_addr;

    @(posedge clk);
    if (!rst) begin
      modelWait = 0;
      retOwner  = 0;
      retData   = '0;
      for (int i = 0; i < DEPTH; i++) refMem[i] = initWord(i);
    end else begin
      retOwner = 0;
      retData  = '0;
      if (expCore) begin
        if (core_we) refMem[core_addr[AW-1:0]] = core_wdata;
        else begin retOwner = 1; retData = refMem[core_addr[AW-1:0]]; end
      end else if (expLd) begin
        if (ld_we) refMem[ld_addr[AW-1:0]] = ld_wdata;
        else begin retOwner = 2; retData = refMem[ld_addr[AW-1:0]]; end
      end
      if (ld_req && !expLd) modelWait = (modelWait + 1 > STARVE_MAX) ? STARVE_MAX : modelWait + 1;
      else modelWait = 0;
    end
    @(negedge clk);
  endtask

  // Convenience setters for the two request ports.
  task automatic setCore(input logic req, input logic we, input logic [31:0] addr, input logic [DW-1:0] wdata);
    core_req = req; core_we = we; core_addr = addr; core_wdata = wdata;
  endtask

  task automatic setLd(input logic req, input logic we, input logic [31:0] addr, input logic [DW-1:0] wdata);
    ld_req = req; ld_we = we; ld_addr = addr; ld_wdata = wdata;
  endtask

  // Directed scenarios first, then randomized traffic from two requesters
  // that hold their request until the model says it was granted.
  initial begin
    checks    = 0;
    failures  = 0;
    modelWait = 0;
    retOwner  = 0;
    retData   = '0;
    for (int i = 0; i < DEPTH; i++) refMem[i] = initWord(i);
    rst = 1'b0;
    setCore(1'b0, 1'b0, '0, '0);
    setLd(1'b0, 1'b0, '0, '0);
    @(negedge clk);

    // Reset with both ports requesting: everything must stay quiet.
    setCore(1'b1, 1'b0, 32'd28, '0);
    setLd(1'b1, 1'b0, 32'd3, '0);
    applyStimulus();
    applyStimulus();
    checkOutput("reset_gnt", {lastCoreGnt, lastLdGnt, lastMemEn, lastMemWe}, 4'b0000);

    // Core load of word 28 returns 0xF0 the next cycle.
    rst = 1'b1;
    setLd(1'b0, 1'b0, '0, '0);
    applyStimulus();
    checkOutput("core_load_gnt", lastCoreGnt, 1'b1);
    setCore(1'b0, 1'b0, '0, '0);
    applyStimulus();
    checkOutput("core_load_ret", {lastCoreRvalid, lastCoreRdata, lastLdRvalid}, {1'b1, 32'h0000_00F0, 1'b0});

    // Both ports hammering: loader wins every fifth cycle, core stalls then.
    setCore(1'b1, 1'b0, 32'd40, '0);
    setLd(1'b1, 1'b0, 32'd41, '0);
    for (int c = 1; c <= 15; c++) begin
      applyStimulus();
      checkOutput("starve_ld_gnt", lastLdGnt, (c % 5) == 0);
      checkOutput("starve_stall", lastCoreStall, (c % 5) == 0);
    end

    // Loader store to 248 then core load of 248 sees the stored word.
    setCore(1'b0, 1'b0, '0, '0);
    setLd(1'b0, 1'b0, '0, '0);
    applyStimulus();
    setLd(1'b1, 1'b1, 32'd248, 32'hF000_00AC);
    applyStimulus();
    checkOutput("ld_store_we", {lastLdGnt, lastMemEn, lastMemWe}, 3'b111);
    setLd(1'b0, 1'b0, '0, '0);
    setCore(1'b1, 1'b0, 32'd248, '0);
    applyStimulus();
    checkOutput("core_load_after_store", {lastMemEn, lastMemWe}, 2'b10);
    setCore(1'b0, 1'b0, '0, '0);
    applyStimulus();
    checkOutput("store_load_data", lastCoreRdata, 32'hF000_00AC);

    // Core, loader, core loads back to back: returns alternate in order.
    setCore(1'b1, 1'b0, 32'd5, '0);
    applyStimulus();
    setCore(1'b0, 1'b0, '0, '0);
    setLd(1'b1, 1'b0, 32'd6, '0);
    applyStimulus();
    checkOutput("b2b_ret1", {lastCoreRvalid, lastLdRvalid, lastCoreRdata}, {2'b10, initWord(5)});
    setLd(1'b0, 1'b0, '0, '0);
    setCore(1'b1, 1'b0, 32'd7, '0);
    applyStimulus();
    checkOutput("b2b_ret2", {lastCoreRvalid, lastLdRvalid, lastLdRdata}, {2'b01, initWord(6)});
    setCore(1'b0, 1'b0, '0, '0);
    applyStimulus();
    checkOutput("b2b_ret3", {lastCoreRvalid, lastLdRvalid, lastCoreRdata}, {2'b10, initWord(7)});

    // Load requested while reset is sampled low yields no return afterwards.
    setCore(1'b1, 1'b0, 32'd9, '0);
    rst = 1'b0;
    applyStimulus();
    checkOutput("reset_load_quiet", {lastCoreGnt, lastMemEn}, 2'b00);
    rst = 1'b1;
    setCore(1'b0, 1'b0, '0, '0);
    applyStimulus();
    checkOutput("reset_load_no_ret", lastCoreRvalid, 1'b0);

    // Address above the memory size wraps onto word 0.
    setCore(1'b1, 1'b0, 32'h0000_0400, '0);
    applyStimulus();
    checkOutput("addr_trunc", {lastMemEn, lastMemAddr}, {1'b1, 10'd0});
    setCore(1'b0, 1'b0, '0, '0);
    applyStimulus();

    // Randomized traffic with occasional reset pulses.
    for (int n = 0; n < 2000; n++) begin
      if (!core_req && $urandom_range(0, 9) < 6)
        setCore(1'b1, $urandom_range(0, 2) == 0, ($urandom & 32'hFFFF_FC00) | 32'($urandom_range(0, 15)), $urandom);
      if (!ld_req && $urandom_range(0, 9) < 7)
        setLd(1'b1, $urandom_range(0, 2) == 0, ($urandom & 32'hFFFF_FC00) | 32'($urandom_range(0, 15)), $urandom);
      rst = ($urandom_range(0, 59) != 0);
      applyStimulus();
      if (expCore) setCore(1'b0, 1'b0, '0, '0);
      if (expLd) setLd(1'b0, 1'b0, '0, '0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/dmem_arbiter.md
DMEM_ARBITER -- requirements
Module: dmem_arbiter

Parameters
REQ-001 AW, default 10, word-address width of the shared data memory (1024 words).
REQ-002 DW, default 32, data width.
REQ-003 STARVE_MAX, default 4, loader wait-cycle limit before forced loader grant; legal range 1..15.

Interface
REQ-004 clk  in  1  single clock; all state updates on posedge clk.
REQ-005 rst  in  1  reset, synchronous, active-low.
REQ-006 core_req  in  1  memory-stage access request.
REQ-007 core_we  in  1  1 = store, 0 = load.
REQ-008 core_addr  in  32  word address; bits [AW-1:0] used, upper bits ignored.
REQ-009 core_wdata  in  DW  store data.
REQ-010 core_gnt  out  1  combinational grant for the current cycle.
REQ-011 core_stall  out  1  core_req & ~core_gnt; holds the pipeline memory stage.
REQ-012 core_rvalid / core_rdata  out  1 / DW  load-return strobe and data.
REQ-013 ld_req, ld_we, ld_addr[31:0], ld_wdata[DW-1:0]  in  loader/debug port, same meaning as core port.
REQ-014 ld_gnt, ld_rvalid, ld_rdata[DW-1:0]  out  loader grant and load return.
REQ-015 mem_en, mem_we  out  1  memory access strobe and write enable.
REQ-016 mem_addr  out  AW  memory word address; mem_wdata  out  DW  write data.
REQ-017 mem_rdata  in  DW  memory read data, valid one cycle after mem_en & ~mem_we.

Function
REQ-018 Each cycle at most one requester is granted; grant is combinational from the requests and the wait counter.
REQ-019 Default priority: core over loader.
REQ-020 Forced loader grant: if ld_req=1 and wait_cnt==STARVE_MAX, the loader is granted even when core_req=1, and core_stall=1.
REQ-021 wait_cnt (4 bits): +1 per cycle with ld_req=1 & ld_gnt=0, saturating at STARVE_MAX; cleared to 0 on any cycle with ld_gnt=1 or ld_req=0.
REQ-022 Granted requester drives memory: mem_en=1, mem_we=<req>_we, mem_addr=<req>_addr[AW-1:0], mem_wdata=<req>_wdata.
REQ-023 No grant: mem_en=0, mem_we=0, mem_addr=0, mem_wdata=0.
REQ-024 Read-owner state rd_own has three states: NONE, CORE, LD.
  - Next state CORE on a granted core load, LD on a granted loader load, NONE otherwise.
REQ-025 Load latency is exactly 1 cycle.
  - rd_own==CORE: core_rvalid=1, core_rdata=mem_rdata.
  - rd_own==LD: ld_rvalid=1, ld_rdata=mem_rdata.
  - Non-owner rvalid=0 and rdata=0.
REQ-026 Stores produce no rvalid; a store is complete in its grant cycle.
REQ-027 Back-to-back loads from either or mixed requesters sustain one access per cycle; returns stay in grant order.
REQ-028 Load granted in the cycle after a store to the same address returns the stored value (memory ordering; no bypass logic in this block).
REQ-029 A requester must hold its req/we/addr/wdata stable until granted; the block does not latch requests.

Reset
REQ-030 While rst=0 at posedge clk:
  - wait_cnt=0, rd_own=NONE.
  - all gnt, rvalid, mem_en and mem_we outputs forced to 0; rdata outputs 0; core_stall=0.
REQ-031 A load granted in the cycle reset is sampled low is discarded: no rvalid in the following cycle.
REQ-032 First arbitration occurs in the first cycle after rst returns high.

Verification
REQ-033 Core load of addr 28 with memory holding 0x000000F0 -> core_gnt=1 same cycle; core_rvalid=1, core_rdata=0x000000F0 next cycle; ld_rvalid=0.
REQ-034 core_req and ld_req held high continuously, STARVE_MAX=4 -> loader granted on the 5th cycle with core_stall=1 that cycle; wait_cnt back to 0; pattern repeats every 5 cycles.
REQ-035 Loader store 0xF00000AC to addr 248, then core load of 248 next cycle -> mem_we=1 then mem_en=1 & mem_we=0; core_rdata=0xF00000AC one cycle later.
REQ-036 Core load, loader load, core load on consecutive cycles (no contention) -> rvalid toggles core, ld, core on the following three cycles, each with the correct data.
REQ-037 Core load granted, rst=0 on that same edge -> no core_rvalid next cycle; all outputs 0 during reset.
REQ-038 core_addr=0x00000400 with AW=10 -> mem_addr=0 (upper bits truncated).
